// File: rtl/fp_pkg.sv
// Shared definitions for the sequential binary32 subtractor.
// Holds binary32 field geometry, the 49-bit working-fraction layout,
// the alignment cap, exponent limits and the FSM state enumeration.
package fp_pkg;

  // binary32 field geometry
  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned SIGN_POS = 31;
  localparam int unsigned EXP_LSB  = 23;

  // Working fraction: carry at [48], hidden bit at [47], result LSB at [24]
  localparam int unsigned DP_W      = 49;
  localparam int unsigned CARRY_POS = 48;
  localparam int unsigned HID_POS   = 47;
  localparam int unsigned LSB_POS   = 24;
  localparam int unsigned GUARD_POS = 23;

  // Beyond this exponent difference the smaller operand cannot matter
  localparam int unsigned ALIGN_CAP = 25;

  // Internal exponent is signed and wide enough for +2 carries and NORM underflow
  localparam int unsigned EXPI_W  = 10;
  localparam int          EXP_INF = 255;

  localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;
  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND
  } state_t;

  // Expand a binary32 exponent/fraction into the working layout; exponent 0 reads as zero
  function automatic logic [DP_W-1:0] dp_frac(input logic [EXP_W-1:0]  e,
                                              input logic [FRAC_W-1:0] f);
    dp_frac = (e == EXP_ZERO) ? '0 : {2'b01, f, {LSB_POS{1'b0}}};
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, overflow/underflow handling and binary32 packing.
// Ports:
//   sign    - result sign
//   exp_in  - signed biased exponent of the normalised fraction
//   frac    - normalised 49-bit working fraction (hidden bit at [47])
//   word_c  - packed binary32 result (combinational)
module fp_round_pack
  import fp_pkg::*;
(
  input  logic                     sign,
  input  logic signed [EXPI_W-1:0] exp_in,
  input  logic [DP_W-1:0]          frac,
  output logic [FP_W-1:0]          word_c
);

  localparam int unsigned KEEP_W = DP_W - LSB_POS;

  logic [KEEP_W-1:0]        kept;
  logic [KEEP_W-1:0]        rounded;
  logic                     guard;
  logic                     sticky;
  logic                     inc;
  logic [FRAC_W-1:0]        mant;
  logic signed [EXPI_W-1:0] exp_f;

  // Round on [48:24], renormalise a rounding carry, then saturate or flush
  always_comb begin
    kept    = frac[DP_W-1:LSB_POS];
    guard   = frac[GUARD_POS];
    sticky  = |frac[GUARD_POS-1:0];
    inc     = guard & (sticky | frac[LSB_POS]);
    rounded = kept + KEEP_W'(inc);
    mant    = rounded[FRAC_W-1:0];
    exp_f   = exp_in;
    if (rounded[KEEP_W-1]) begin
      mant  = rounded[FRAC_W:1];
      exp_f = exp_in + EXPI_W'(1);
    end
    if (exp_f <= EXPI_W'(0)) begin
      word_c = '0;
    end else if (exp_f >= EXPI_W'(EXP_INF)) begin
      word_c = {sign, EXP_MAX, FRAC_W'(0)};
    end else begin
      word_c = {sign, exp_f[EXP_W-1:0], mant};
    end
  end

endmodule

// File: rtl/fsub_seq.sv
// Multi-cycle IEEE-754 binary32 subtractor computing a - b.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   start    - request, sampled only while idle
//   a, b     - minuend and subtrahend (binary32)
//   busy     - high whenever the FSM is not idle
//   done     - one-cycle pulse when out carries a new result
//   out      - result, held until the next result is produced
module fsub_seq
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [FP_W-1:0] out
);

  state_t                   state_q, state_d;
  logic                     sign_a_q, sign_a_d;
  logic                     sign_b_q, sign_b_d;
  logic                     sign_r_q, sign_r_d;
  logic [DP_W-1:0]          big_q, big_d;
  logic [DP_W-1:0]          small_q, small_d;
  logic signed [EXPI_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0]         cnt_q, cnt_d;
  logic                     busy_d;
  logic                     done_d;
  logic [FP_W-1:0]          out_d;

  logic [EXP_W-1:0] exp_a_c, exp_b_c;
  logic             b_larger_c;
  logic [DP_W-1:0]  frac_a_c, frac_b_c;
  logic [DP_W-1:0]  sum_c;
  logic [FP_W-1:0]  packed_c;

  // Operand decode; larger operand chosen on raw magnitude bits
  assign exp_a_c    = a[EXP_LSB +: EXP_W];
  assign exp_b_c    = b[EXP_LSB +: EXP_W];
  assign b_larger_c = a[SIGN_POS-1:0] < b[SIGN_POS-1:0];
  assign frac_a_c   = dp_frac(exp_a_c, a[FRAC_W-1:0]);
  assign frac_b_c   = dp_frac(exp_b_c, b[FRAC_W-1:0]);

  // Larger magnitude is always in big_q, so the difference never goes negative
  assign sum_c = (sign_a_q == sign_b_q) ? big_q + small_q : big_q - small_q;

  fp_round_pack u_round_pack (
    .sign   (sign_r_q),
    .exp_in (exp_q),
    .frac   (big_q),
    .word_c (packed_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sign_r_d = sign_r_q;
    big_d    = big_q;
    small_d  = small_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    out_d    = out;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_a_d = a[SIGN_POS];
          sign_b_d = ~b[SIGN_POS];
          if (b_larger_c) begin
            sign_r_d = ~b[SIGN_POS];
            big_d    = frac_b_c;
            small_d  = frac_a_c;
            exp_d    = $signed(EXPI_W'(exp_b_c));
            cnt_d    = exp_b_c - exp_a_c;
          end else begin
            sign_r_d = a[SIGN_POS];
            big_d    = frac_a_c;
            small_d  = frac_b_c;
            exp_d    = $signed(EXPI_W'(exp_a_c));
            cnt_d    = exp_a_c - exp_b_c;
          end
          state_d = ALIGN;
        end
      end

      // One bit per cycle, or clear outright when the gap is too large
      ALIGN: begin
        if (cnt_q > EXP_W'(ALIGN_CAP)) begin
          small_d = '0;
          state_d = ADD;
        end else if (cnt_q == '0) begin
          state_d = ADD;
        end else begin
          small_d = small_q >> 1;
          cnt_d   = cnt_q - EXP_W'(1);
        end
      end

      ADD: begin
        if (sum_c == '0) begin
          out_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          big_d   = sum_c;
          state_d = NORM;
        end
      end

      NORM: begin
        if (big_q[CARRY_POS]) begin
          big_d   = big_q >> 1;
          exp_d   = exp_q + EXPI_W'(1);
          state_d = ROUND;
        end else if (big_q[HID_POS]) begin
          state_d = ROUND;
        end else begin
          big_d = big_q << 1;
          exp_d = exp_q - EXPI_W'(1);
        end
      end

      ROUND: begin
        out_d   = packed_c;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sign_r_q <= 1'b0;
      big_q    <= '0;
      small_q  <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sign_r_q <= sign_r_d;
      big_q    <= big_d;
      small_q  <= small_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      out      <= out_d;
    end
  end

endmodule

// File: tb/tb_fsub_seq.sv
// Self-checking bench for fsub_seq: transaction-level reference model,
// per-cycle output comparison, directed literal cases and random traffic.
module tb_fsub_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int          n_vec;
  int          n_fail;

  // Reference model state (updated on every rising edge)
  int          cyc;
  bit          pend;
  int          due;
  logic [31:0] pend_res;
  logic [31:0] last_out;
  logic [31:0] m_r;
  int          m_l;

  int          acc;
  int          pulses;
  int          tt;
  logic [7:0]  ea;

  fsub_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic checkint(input string nm, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Arithmetic reference: result word and edges from acceptance to done
  function automatic void model_sub(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] res, output int lat);
    logic [48:0] fx, fy, big, sml, s;
    logic [24:0] m;
    logic [23:0] rem;
    int          ex, ey, e, d, n;
    logic        sy, bl, sg;
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    fx  = (ex == 0) ? 49'd0 : {2'b01, x[22:0], 24'd0};
    fy  = (ey == 0) ? 49'd0 : {2'b01, y[22:0], 24'd0};
    sy  = ~y[31];
    bl  = (x[30:0] < y[30:0]);
    sg  = bl ? sy : x[31];
    big = bl ? fy : fx;
    sml = bl ? fx : fy;
    e   = bl ? ey : ex;
    d   = bl ? (ey - ex) : (ex - ey);
    if (d > 25) begin
      sml = 49'd0;
      d   = 0;
    end else begin
      sml = sml >> d;
    end
    s = (x[31] == sy) ? big + sml : big - sml;
    if (s == 49'd0) begin
      res = 32'd0;
      lat = 2 + d;
      return;
    end
    n = 0;
    while (s < (49'd1 << 47)) begin
      s = s << 1;
      e--;
      n++;
    end
    if (s >= (49'd1 << 48)) begin
      s = s >> 1;
      e++;
    end
    m   = s[48:24];
    rem = s[23:0];
    if (rem > 24'h800000 || (rem == 24'h800000 && m[0])) m = m + 25'd1;
    if (m >= (25'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    if (e <= 0)        res = 32'd0;
    else if (e >= 255) res = {sg, 8'hFF, 23'd0};
    else               res = {sg, 8'(e), m[22:0]};
    lat = 4 + d + n;
  endfunction

  // Model: commit result at its done edge, accept start only when idle
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend     = 1'b0;
      last_out = 32'd0;
    end else begin
      if (pend && cyc == due) last_out = pend_res;
      if (start && (!pend || cyc > due)) begin
        model_sub(a_i, b_i, m_r, m_l);
        pend_res = m_r;
        due      = cyc + m_l;
        pend     = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check32("rst_out", out, 32'd0);
    end else begin
      check1("busy", busy, pend && (cyc < due));
      check1("done", done, pend && (cyc == due));
      if (!(pend && (cyc < due))) check32("out", out, last_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 300 && busy; t++) tick();
    if (busy) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_idle: busy still %b after 300 cycles", busy);
    end
  endtask

  // Directed case: pin the model to literals, then run the DUT against the same literals
  task automatic run_dir(input logic [31:0] ta, input logic [31:0] tb_op,
                         input logic [31:0] want, input int want_lat, input string nm);
    logic [31:0] mres;
    int          mlat;
    int          k;
    bit          seen;
    model_sub(ta, tb_op, mres, mlat);
    check32({nm, "_model_out"}, mres, want);
    checkint({nm, "_model_lat"}, mlat, want_lat);
    wait_idle();
    a_i   = ta;
    b_i   = tb_op;
    start = 1'b1;
    tick();
    start = 1'b0;
    k     = cyc;
    seen  = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: done=%b want 1 within 200 cycles", nm, done);
    end else begin
      check32({nm, "_out"}, out, want);
      checkint({nm, "_lat"}, cyc - k, want_lat);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    cyc    = 0;
    pend   = 1'b0;
    due    = 0;
    last_out = 32'd0;
    pend_res = 32'd0;
    rst   = 1'b1;
    start = 1'b0;
    a_i   = 32'd0;
    b_i   = 32'd0;
    repeat (3) tick();
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check32("reset_out", out, 32'd0);
    rst = 1'b0;
    tick();

    // Consecutive calls start in the done cycle of the previous one
    run_dir(32'h40400000, 32'h3F800000, 32'h40000000, 5,  "three_minus_one");
    run_dir(32'h3F800000, 32'h3F800000, 32'h00000000, 2,  "equal_zero");
    run_dir(32'h3F800000, 32'hBF800000, 32'h40000000, 4,  "one_minus_neg_one");
    run_dir(32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 29, "one_minus_ulp");
    run_dir(32'h3F800000, 32'h00000001, 32'h3F800000, 4,  "denormal_b");
    run_dir(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4,  "overflow_inf");
    run_dir(32'h00C00000, 32'h00800000, 32'h00000000, 5,  "underflow_zero");
    run_dir(32'h3F800001, 32'h33800000, 32'h3F800000, 28, "tie_even_down");
    run_dir(32'h3F800002, 32'h33800000, 32'h3F800002, 28, "tie_odd_up");
    run_dir(32'h3FFFFFFF, 32'hB3800000, 32'h40000000, 28, "round_carry");

    // start pulsed while busy must be ignored
    wait_idle();
    a_i = 32'h3F800000; b_i = 32'h33800000; start = 1'b1;
    tick();
    start = 1'b0;
    acc = cyc;
    repeat (5) tick();
    a_i = 32'h40400000; b_i = 32'h12345678; start = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    for (int t = 0; t < 60; t++) begin
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          check32("spur_out", out, 32'h3F7FFFFF);
          checkint("spur_lat", cyc - acc, 29);
        end
      end
      tick();
    end
    checkint("spur_pulses", pulses, 1);

    // Reset in the middle of a long ALIGN
    wait_idle();
    a_i = 32'h3F800000; b_i = 32'h33800000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check1("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check32("abort_out", out, 32'd0);
    tick();
    tick();
    rst    = 1'b0;
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      if (done) pulses++;
      tick();
    end
    checkint("abort_no_done", pulses, 0);
    run_dir(32'h40400000, 32'h3F800000, 32'h40000000, 5, "after_abort");
    run_dir(32'hC0400000, 32'h3F800000, 32'hC0800000, 5, "neg_three_minus_one");

    // Random traffic, including starts while busy, back-to-back and stray resets
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      ea    = 8'($urandom_range(48, 254));
      a_i   = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
      case ($urandom_range(0, 5))
        0: b_i = {1'($urandom_range(0, 1)), 8'($urandom_range(48, 254)), 23'($urandom)};
        1: b_i = {1'($urandom_range(0, 1)), a_i[30:8], 8'($urandom)};
        2: b_i = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
        default: begin
          tt = int'(ea) + int'($urandom_range(0, 30)) - 15;
          if (tt > 254) tt = 254;
          b_i = {1'($urandom_range(0, 1)), 8'(tt), 23'($urandom)};
        end
      endcase
      if ($urandom_range(0, 19) == 0) a_i[30:23] = 8'h00;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    repeat (100) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fsub_seq.md
FSUB_SEQ -- requirements
Module: fsub_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request to compute a - b; sampled only in IDLE.
REQ-004 a  input  32  minuend, IEEE-754 binary32.
REQ-005 b  input  32  subtrahend, IEEE-754 binary32.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse; out is valid from this cycle onward.
REQ-008 out  output  32  binary32 result; held until the next accepted start.

Function
REQ-009 The block SHALL be a multi-cycle sequential IEEE-754 binary32 subtractor using FSM states IDLE, ALIGN, ADD, NORM, ROUND.
REQ-010 In IDLE with start=1, the block SHALL register a, b and the internal effective sign sign_b' = ~b[31], then enter ALIGN; start outside IDLE SHALL be ignored.
REQ-011 Operands with exponent 0 (zero or denormal) SHALL be treated as 0 (fraction 0); NaN/Inf inputs are outside scope and not detected.
REQ-012 Larger/smaller selection: b is larger iff a[30:0] < b[30:0]; result sign = sign of larger operand (sign_b' if b larger, a[31] otherwise).
REQ-013 Datapath: 49-bit fractions {2'b01, frac23, 24'b0}, with hidden bit at [47] and carry at [48].
REQ-014 ALIGN: shift count d = |exp_a - exp_b|; if d > 25, smaller fraction SHALL be cleared in one cycle; otherwise shift smaller right 1 bit per cycle; leave ALIGN in the cycle the count reaches 0 (d+1 cycles).
REQ-015 ADD (1 cycle): if a[31] == sign_b', compute larger + smaller; otherwise compute larger - smaller.
REQ-016 If the ADD result is 0: out = 32'h00000000; skip NORM; done in the following cycle.
REQ-017 NORM, one decision per cycle:
  - bit48=1: shift right 1, exponent+1, exit.
  - bit47=1: exit.
  - otherwise: shift left 1, exponent-1.
REQ-018 Rounding in ROUND, round-to-nearest-even:
  - increment [48:24] if bit23 & |[22:0];
  - or if bit24 & bit23 & ~|[22:0].
  - If rounding carries into bit48, shift right 1 and exponent+1.
REQ-019 Final exponent 0 (underflow during NORM) SHALL give out = 32'h00000000.
REQ-020 Final exponent >= 255 SHALL give out = {sign, 8'hFF, 23'h0}.
REQ-021 Otherwise out = {sign, exponent[7:0], fraction[46:24]}.
REQ-022 out and done SHALL be registered; done is high for exactly the one cycle after ROUND; FSM returns to IDLE in that same cycle.
REQ-023 Latency (start sampled at edge 0): done high in cycle 4 + d + n, where n = NORM left shifts (d = 0 when the smaller fraction is cleared).
REQ-024 start asserted in the same cycle done is high SHALL be accepted (back-to-back operation).

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, out=32'h0 and clear all datapath registers, including mid-operation.
REQ-026 No result or done pulse SHALL appear for an operation aborted by reset; the first start after rst falls SHALL be accepted normally.

Structure
REQ-027 Shared package fp_pkg SHALL hold: FP32 field widths/positions, datapath width 49, alignment cap 25, exponent limits 8'h00/8'hFF, and the FSM state enumeration.
REQ-028 Rounding, overflow and packing (REQ-018 to REQ-021) SHALL be one combinational sub-module, fp_round_pack, instantiated once.

Verification
REQ-029 a=0x40400000, b=0x3F800000 (3.0-1.0) -> out=0x40000000, done at cycle 5 (d=1, n=0).
REQ-030 a=0x3F800000, b=0x3F800000 -> out=0x00000000; a=0x3F800000, b=0xBF800000 -> out=0x40000000.
REQ-031 a=0x3F800000, b=0x33800000 (1-2^-24) -> out=0x3F7FFFFF; a=0x3F800000, b=0x00000001 (denormal) -> out=0x3F800000.
REQ-032 a=0x7F7FFFFF, b=0xFF7FFFFF -> out=0x7F800000 (overflow saturates to +Inf).
REQ-033 start pulsed while busy -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-034 rst asserted during ALIGN of a 24-shift operation -> busy, done and out are 0 immediately; no done follows; the next operation is correct.
